// File: rtl/alu_pkg.sv
// Shared definitions for the multi-cycle ALU sequencer: opcodes, FSM states, error bits.
// Latency: n/a (declarations only).
// Backpressure: n/a.
package alu_pkg;

   localparam logic [3:0] OP_ADD = 4'b0010;
   localparam logic [3:0] OP_SUB = 4'b0011;
   localparam logic [3:0] OP_MUL = 4'b0100;
   localparam logic [3:0] OP_DIV = 4'b0101;
   localparam logic [3:0] OP_MOD = 4'b0110;

   // ERR bit positions: SUB borrow and divide-by-zero
   localparam int ERR_OVF = 0;
   localparam int ERR_DZE = 1;

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      ITER = 2'd1,
      DONE = 2'd2
   } state_t;

   // Iteration core mode: shift-add multiply or restoring divide
   typedef enum logic {
      MODE_MUL = 1'b0,
      MODE_DIV = 1'b1
   } iter_mode_t;

endpackage

// File: rtl/alu_iter_core.sv
// Iterative engine: shift-add multiply or restoring divide, one bit per cycle.
// Latency: WIDTH cycles after i_start; o_done is high during the final iteration cycle.
// Backpressure: none; the FSM starts it only when idle and discards it through reset.
module alu_iter_core
   import alu_pkg::*;
#(
   parameter int WIDTH = 16
) (
   input  logic               i_clk,
   input  logic               i_rst,
   input  logic               i_start,
   input  iter_mode_t         i_mode,
   input  logic [WIDTH-1:0]   i_a,
   input  logic [WIDTH-1:0]   i_b,
   output logic               o_done,
   output logic [2*WIDTH-1:0] o_res_nxt
);

   localparam int CW = $clog2(WIDTH + 1);

   // r_acc: upper half = partial product / remainder, lower half = multiplier / dividend-quotient
   logic [2*WIDTH-1:0] r_acc;
   logic [WIDTH-1:0]   r_opnd;
   iter_mode_t         r_mode;
   logic [CW-1:0]      r_cnt;
   logic               r_active;

   logic [WIDTH:0]     w_mul_sum;
   logic [2*WIDTH-1:0] w_mul_nxt;
   logic [WIDTH:0]     w_div_trial;
   logic               w_div_ge;
   logic [WIDTH-1:0]   w_div_sub;
   logic [2*WIDTH-1:0] w_div_nxt;

   // Multiply step: add multiplicand when the multiplier LSB is set, then shift right
   assign w_mul_sum = {1'b0, r_acc[2*WIDTH-1:WIDTH]} + {1'b0, r_opnd & {WIDTH{r_acc[0]}}};
   assign w_mul_nxt = {w_mul_sum, r_acc[WIDTH-1:1]};

   // Divide step: shift the next dividend bit into the remainder and trial-subtract.
   // When the subtraction fits, the true difference is below 2^WIDTH, so a WIDTH-bit
   // subtract is exact.
   assign w_div_trial = r_acc[2*WIDTH-1:WIDTH-1];
   assign w_div_ge    = (w_div_trial >= {1'b0, r_opnd});
   assign w_div_sub   = w_div_trial[WIDTH-1:0] - r_opnd;
   assign w_div_nxt   = w_div_ge ? {w_div_sub, r_acc[WIDTH-2:0], 1'b1}
                                 : {w_div_trial[WIDTH-1:0], r_acc[WIDTH-2:0], 1'b0};

   assign o_res_nxt = (r_mode == MODE_DIV) ? w_div_nxt : w_mul_nxt;
   assign o_done    = r_active && (r_cnt == CW'(WIDTH - 1));

   // Load operands on start, then advance one bit per cycle until the last iteration
   always_ff @(posedge i_clk) begin
      if (i_rst) begin
         r_acc    <= '0;
         r_opnd   <= '0;
         r_mode   <= MODE_MUL;
         r_cnt    <= '0;
         r_active <= 1'b0;
      end else if (i_start) begin
         r_acc    <= {{WIDTH{1'b0}}, i_a};
         r_opnd   <= i_b;
         r_mode   <= i_mode;
         r_cnt    <= '0;
         r_active <= 1'b1;
      end else if (r_active) begin
         r_acc <= o_res_nxt;
         if (o_done) begin
            r_active <= 1'b0;
            r_cnt    <= '0;
         end else begin
            r_cnt <= r_cnt + CW'(1);
         end
      end
   end

endmodule

// File: rtl/alu_sequencer.sv
// Multi-cycle ALU controller (ADD/SUB 1 cycle, MUL/DIV/MOD iterative); optional ALU_CHAIN_EN reuses last result as IN1.
// Latency: RSP_VALID 1 cycle after accept for ADD/SUB/NOP/divide-by-zero, WIDTH+1 cycles for MUL/DIV/MOD.
// Backpressure: result held in DONE until RSP_READY; CMD_READY low outside IDLE, so the source must hold CMD_VALID.
module alu_sequencer
   import alu_pkg::*;
#(
   parameter int WIDTH = 16
) (
   input  logic               CLK,
   input  logic               RST,
   input  logic               CMD_VALID,
   output logic               CMD_READY,
   input  logic [WIDTH-1:0]   IN1,
   input  logic [WIDTH-1:0]   IN2,
   input  logic [3:0]         OP,
   input  logic               CMD_CHAIN,
   output logic               RSP_VALID,
   input  logic               RSP_READY,
   output logic [2*WIDTH-1:0] OUT,
   output logic [1:0]         ERR,
   output logic               BUSY
);

   state_t             r_state;
   state_t             w_state_nxt;
   logic [3:0]         r_op;
   logic [2*WIDTH-1:0] r_out;
   logic [1:0]         r_err;

   logic [WIDTH-1:0]   w_in1;
   logic [WIDTH:0]     w_add;
   logic               w_start;
   iter_mode_t         w_mode;
   logic               w_load;
   logic [2*WIDTH-1:0] w_out_nxt;
   logic [1:0]         w_err_nxt;
   logic               w_core_done;
   logic [2*WIDTH-1:0] w_core_res;

`ifdef ALU_CHAIN_EN
   logic [WIDTH-1:0]   r_chain;

   assign w_in1 = CMD_CHAIN ? r_chain : IN1;

   // Remember the low half of each result as it is delivered to the consumer
   always_ff @(posedge CLK) begin
      if (RST) begin
         r_chain <= '0;
      end else if ((r_state == DONE) && RSP_READY) begin
         r_chain <= r_out[WIDTH-1:0];
      end
   end
`else
   logic w_unused_chain;

   assign w_in1          = IN1;
   assign w_unused_chain = CMD_CHAIN;
`endif

   assign w_add = {1'b0, w_in1} + {1'b0, IN2};

   alu_iter_core #(
      .WIDTH     (WIDTH)
   ) u_core (
      .i_clk     (CLK),
      .i_rst     (RST),
      .i_start   (w_start),
      .i_mode    (w_mode),
      .i_a       (w_in1),
      .i_b       (IN2),
      .o_done    (w_core_done),
      .o_res_nxt (w_core_res)
   );

   // FSM state register; reset abandons any iteration in flight
   always_ff @(posedge CLK) begin
      if (RST) begin
         r_state <= IDLE;
      end else begin
         r_state <= w_state_nxt;
      end
   end

   // Next state, core start, and the result to capture on entry to DONE
   always_comb begin
      w_state_nxt = r_state;
      w_start     = 1'b0;
      w_mode      = MODE_MUL;
      w_load      = 1'b0;
      w_out_nxt   = '0;
      w_err_nxt   = '0;
      case (r_state)
         IDLE: begin
            if (CMD_VALID) begin
               case (OP)
                  OP_ADD: begin
                     w_state_nxt = DONE;
                     w_load      = 1'b1;
                     w_out_nxt   = {{(WIDTH-1){1'b0}}, w_add};
                  end
                  OP_SUB: begin
                     w_state_nxt        = DONE;
                     w_load             = 1'b1;
                     w_out_nxt          = {{WIDTH{1'b0}}, w_in1} - {{WIDTH{1'b0}}, IN2};
                     w_err_nxt[ERR_OVF] = (w_in1 < IN2);
                  end
                  OP_MUL: begin
                     w_state_nxt = ITER;
                     w_start     = 1'b1;
                     w_mode      = MODE_MUL;
                  end
                  OP_DIV, OP_MOD: begin
                     if (IN2 == '0) begin
                        w_state_nxt        = DONE;
                        w_load             = 1'b1;
                        w_err_nxt[ERR_DZE] = 1'b1;
                     end else begin
                        w_state_nxt = ITER;
                        w_start     = 1'b1;
                        w_mode      = MODE_DIV;
                     end
                  end
                  default: begin
                     w_state_nxt = DONE;
                     w_load      = 1'b1;
                  end
               endcase
            end
         end
         ITER: begin
            if (w_core_done) begin
               w_state_nxt = DONE;
               w_load      = 1'b1;
               if (r_op == OP_MUL) begin
                  w_out_nxt = w_core_res;
               end else if (r_op == OP_MOD) begin
                  w_out_nxt = {{WIDTH{1'b0}}, w_core_res[2*WIDTH-1:WIDTH]};
               end else begin
                  w_out_nxt = {{WIDTH{1'b0}}, w_core_res[WIDTH-1:0]};
               end
            end
         end
         DONE: begin
            if (RSP_READY) begin
               w_state_nxt = IDLE;
            end
         end
         default: begin
            w_state_nxt = IDLE;
         end
      endcase
   end

   // Latch the opcode on acceptance; capture OUT/ERR on entry to DONE and keep them afterwards
   always_ff @(posedge CLK) begin
      if (RST) begin
         r_op  <= '0;
         r_out <= '0;
         r_err <= '0;
      end else begin
         if ((r_state == IDLE) && CMD_VALID) begin
            r_op <= OP;
         end
         if (w_load) begin
            r_out <= w_out_nxt;
            r_err <= w_err_nxt;
         end
      end
   end

   assign CMD_READY = (r_state == IDLE);
   assign RSP_VALID = (r_state == DONE);
   assign BUSY      = (r_state != IDLE);
   assign OUT       = r_out;
   assign ERR       = r_err;

endmodule

// File: doc/alu_sequencer.md
Name: alu_sequencer

Overview:
Multi-cycle controller for the 16-bit arithmetic unit: ADD, SUB, MUL, DIV and MOD.
- Accepts one command per transaction over a valid/ready handshake.
- Runs MUL as an iterative shift-add and DIV/MOD as an iterative restoring divide, one bit per cycle.
- Registers the 32-bit result and the 2-bit error code, and holds them until the consumer accepts.
- Sits between the command source (testbench/top-level sequencer) and the result consumer; replaces the combinational BreadBoard path where timing matters.

Parameters:
- WIDTH, 16, operand width; result width is 2*WIDTH; iteration count is WIDTH.

Ports:
- CLK  input  1  system clock, rising edge.
- RST  input  1  synchronous, active-high reset.
- CMD_VALID  input  1  command present.
- CMD_READY  output  1  sequencer can accept a command.
- IN1  input  WIDTH  operand 1, unsigned.
- IN2  input  WIDTH  operand 2, unsigned.
- OP  input  4  opcode: 0010 ADD, 0011 SUB, 0100 MUL, 0101 DIV, 0110 MOD, all others NOP.
- CMD_CHAIN  input  1  use previous result low half as IN1 (only with ALU_CHAIN_EN).
- RSP_VALID  output  1  result valid.
- RSP_READY  input  1  consumer accepts result.
- OUT  output  2*WIDTH  result.
- ERR  output  2  bit0 = SUB borrow (IN1<IN2); bit1 = divide-by-zero.
- BUSY  output  1  high in any state other than IDLE.

Behaviour:
- Clock and reset: one clock, CLK. Reset RST is synchronous and active-high.
- Reset values: state=IDLE, CMD_READY=1, RSP_VALID=0, OUT=0, ERR=0, BUSY=0, iteration counter=0.
- RST wins over every other event, including mid-operation. Any in-flight MUL/DIV is discarded and no response is issued.
- FSM states: IDLE, ITER, DONE.
- CMD_READY = (state==IDLE), decoded combinationally from state. The handshake fires when CMD_VALID & CMD_READY; operands and OP are latched that edge.
- ADD, SUB, NOP, DIV/MOD by zero: IDLE->DONE. RSP_VALID is high the cycle after acceptance (latency 1).
- MUL: IDLE->ITER.
  - WIDTH iterations; each adds (IN2 & {WIDTH{multiplier bit}}) to the partial product, then shifts.
  - ITER->DONE when counter==WIDTH-1. RSP_VALID at acceptance+WIDTH+1 (17).
- DIV/MOD with nonzero IN2: IDLE->ITER.
  - Restoring divide, one quotient bit per cycle, same latency as MUL (17).
  - DIV: OUT = zero-extended quotient. MOD: OUT = zero-extended remainder.
- Arithmetic rules:
  - ADD: OUT = IN1+IN2, 17 significant bits, zero-extended; ERR=00.
  - SUB: OUT = (IN1-IN2) mod 2^32, two's complement. ERR[0] = (IN1<IN2).
  - DIV/MOD by zero: OUT=0, ERR=10.
  - NOP: OUT=0, ERR=00.
- DONE state:
  - OUT, ERR and RSP_VALID stay stable until RSP_READY.
  - On RSP_VALID & RSP_READY: DONE->IDLE. RSP_VALID falls the next cycle.
  - No same-cycle accept of a new command; the next command is accepted the cycle after consumption at the earliest.
- CMD_VALID outside IDLE is ignored and must be held by the source.
- OUT/ERR are registered only. They update on entry to DONE and are retained after consumption.

Optional Feature:
- Macro: ALU_CHAIN_EN.
- Defined: on acceptance with CMD_CHAIN=1, IN1 is replaced by the last delivered OUT[WIDTH-1:0]. The register holding that value resets to 0.
- Not defined: the CMD_CHAIN port exists but is ignored, and no chain register is built.

Decomposition:
- Shared package alu_pkg:
  - opcode localparams OP_ADD, OP_SUB, OP_MUL, OP_DIV, OP_MOD;
  - state typedef {IDLE, ITER, DONE};
  - ERR bit indices ERR_OVF=0, ERR_DZE=1.
- One sub-module, alu_iter_core:
  - shared shift register, accumulator and counter;
  - mode input selects shift-add or restoring-subtract;
  - start/done pulses to the FSM.

Test Plan:
- ADD: IN1=11, IN2=51, RSP_READY=1 -> OUT=62, ERR=00, RSP_VALID 1 cycle after accept.
- SUB: IN1=11, IN2=51 -> OUT=0xFFFFFFD8, ERR=01, latency 1.
- MUL: IN1=63271, IN2=46348 -> OUT=0xAECA28D4, ERR=00, RSP_VALID exactly 17 cycles after accept, BUSY high throughout.
- DIV/MOD: 63271/46348 -> OUT=1; MOD -> OUT=16923. DIV 11/0 -> OUT=0, ERR=10, latency 1.
- Backpressure: hold RSP_READY=0 for 5 cycles after MUL completes -> OUT/ERR/RSP_VALID stable, CMD_READY=0; a CMD_VALID pulse in that window is not accepted.
- Reset mid-MUL: assert RST at iteration 8 -> next cycle state IDLE, RSP_VALID=0, OUT=0; a following ADD 2+3 returns 5. With ALU_CHAIN_EN, a chained ADD +1 then returns 6.
